// File: rtl/conv_sum_acc_if.sv
// Product-vector input and pixel-result output bundle for conv_sum_acc.
// The master drives vectors, bias and ReLU control; the slave returns results.
interface conv_sum_acc_if;
   logic         in_valid;
   logic [399:0] inP_25P;
   logic [15:0]  bias;
   logic         relu_en;
   logic         out_valid;
   logic [15:0]  out_sum;
   logic [7:0]   ch_cnt;

   modport master (
      output in_valid, inP_25P, bias, relu_en,
      input  out_valid, out_sum, ch_cnt
   );

   modport slave (
      input  in_valid, inP_25P, bias, relu_en,
      output out_valid, out_sum, ch_cnt
   );
endinterface

// File: rtl/conv_sum_acc.sv
// Reduces 25 Q8.8 products through a registered adder tree, accumulates NUM_CH
// tree sums per pixel, adds bias, saturates to Q8.8 and optionally applies ReLU.
module conv_sum_acc #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned ACC_W  = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   conv_sum_acc_if.slave  bus
);
   typedef logic signed [20:0] elem_t;

   localparam logic [7:0]              LAST    = 8'(NUM_CH - 1);
   localparam logic signed [ACC_W-1:0] MAX_POS = 32767;
   localparam logic signed [ACC_W-1:0] MAX_NEG = -32768;

   elem_t s0 [25];
   elem_t s1 [13];
   elem_t s2 [7];
   elem_t s3 [4];
   elem_t s4 [2];
   elem_t tSum;

   // vld[0] tags s0, vld[5] tags tSum; data registers carry no reset
   logic [5:0]              vld;
   logic [7:0]              chCnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] accNext;
   logic signed [ACC_W-1:0] rSum;
   logic [15:0]             satVal;
   logic [15:0]             resVal;
   logic                    outValid;
   logic [15:0]             outSum;

   for (genvar k = 0; k < 25; k++) begin : gS0
      always_ff @(posedge clk)
         s0[k] <= {{5{bus.inP_25P[16*k+15]}}, bus.inP_25P[16*k +: 16]};
   end

   for (genvar k = 0; k < 12; k++) begin : gS1
      always_ff @(posedge clk) s1[k] <= s0[2*k] + s0[2*k+1];
   end

   for (genvar k = 0; k < 6; k++) begin : gS2
      always_ff @(posedge clk) s2[k] <= s1[2*k] + s1[2*k+1];
   end

   for (genvar k = 0; k < 3; k++) begin : gS3
      always_ff @(posedge clk) s3[k] <= s2[2*k] + s2[2*k+1];
   end

   for (genvar k = 0; k < 2; k++) begin : gS4
      always_ff @(posedge clk) s4[k] <= s3[2*k] + s3[2*k+1];
   end

   always_ff @(posedge clk) begin
      s1[12] <= s0[24];
      s2[6]  <= s1[12];
      s3[3]  <= s2[6];
      tSum   <= s4[0] + s4[1];
   end

   always_comb begin
      accNext = acc + {{(ACC_W-21){tSum[20]}}, tSum};
      rSum    = accNext + {{(ACC_W-16){bus.bias[15]}}, bus.bias};
      if (rSum > MAX_POS)
         satVal = 16'h7FFF;
      else if (rSum < MAX_NEG)
         satVal = 16'h8000;
      else
         satVal = rSum[15:0];
      resVal = (bus.relu_en && satVal[15]) ? 16'h0000 : satVal;
   end

   // clr shares the reset path except that out_sum keeps its last value
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         vld      <= '0;
         chCnt    <= '0;
         acc      <= '0;
         outValid <= 1'b0;
         if (!rst_n) outSum <= '0;
      end else begin
         vld      <= {vld[4:0], bus.in_valid};
         outValid <= 1'b0;
         if (vld[5]) begin
            if (chCnt == LAST) begin
               acc      <= '0;
               chCnt    <= '0;
               outSum   <= resVal;
               outValid <= 1'b1;
            end else begin
               acc   <= accNext;
               chCnt <= chCnt + 8'd1;
            end
         end
      end
   end

   assign bus.out_valid = outValid;
   assign bus.out_sum   = outSum;
   assign bus.ch_cnt    = chCnt;
endmodule

// File: tb/tb_conv_sum_acc.sv
// Directed checks of conv_sum_acc with one instance per channel count (1 and 3).
module tb_conv_sum_acc;
   logic clk = 1'b0;
   logic rst_n;
   logic clr;
   int   total = 0;
   int   bad   = 0;

   conv_sum_acc_if if1 ();
   conv_sum_acc_if if3 ();

   conv_sum_acc #(.NUM_CH(1), .ACC_W(32)) dut1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if1));
   conv_sum_acc #(.NUM_CH(3), .ACC_W(32)) dut3 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(if3));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic v, input logic [15:0] e);
      if1.in_valid = v;
      if1.inP_25P  = {25{e}};
   endtask

   task automatic drive3(input logic v, input logic [15:0] e);
      if3.in_valid = v;
      if3.inP_25P  = {25{e}};
   endtask

   // One vector into the NUM_CH=1 instance, then watch 10 cycles after its sample edge.
   task automatic run1(input logic [15:0] e, input logic [15:0] b, input logic r,
                       output int first, output int cnt, output logic [15:0] val);
      if1.bias    = b;
      if1.relu_en = r;
      drive1(1'b1, e);
      tick();
      drive1(1'b0, 16'h0000);
      first = 0;
      cnt   = 0;
      val   = 16'hxxxx;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (if1.out_valid === 1'b1) begin
            if (first == 0) first = c;
            cnt++;
            val = if1.out_sum;
         end
      end
   endtask

   task automatic feed3(input logic [15:0] e, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         drive3(1'b1, e);
         tick();
         drive3(1'b0, 16'h0000);
         for (int g = 0; g < gap; g++) tick();
      end
   endtask

   task automatic mon3(input int n, output int cnt, output int c0, output int c1,
                       output logic [15:0] v0, output logic [15:0] v1);
      cnt = 0; c0 = 0; c1 = 0; v0 = 16'hxxxx; v1 = 16'hxxxx;
      for (int c = 1; c <= n; c++) begin
         tick();
         if (if3.out_valid === 1'b1) begin
            if (cnt == 0) begin c0 = c; v0 = if3.out_sum; end
            else if (cnt == 1) begin c1 = c; v1 = if3.out_sum; end
            cnt++;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick(); tick();
      total += 6;
      if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b exp=0", if1.out_valid); end
      if (if1.out_sum !== 16'h0000) begin bad++; $display("FAIL reset_sum1 got=%h exp=0000", if1.out_sum); end
      if (if1.ch_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt1 got=%0d exp=0", if1.ch_cnt); end
      if (if3.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid3 got=%b exp=0", if3.out_valid); end
      if (if3.out_sum !== 16'h0000) begin bad++; $display("FAIL reset_sum3 got=%h exp=0000", if3.out_sum); end
      if (if3.ch_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt3 got=%0d exp=0", if3.ch_cnt); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int first, cnt;
      logic [15:0] val;
      run1(16'h0100, 16'h0080, 1'b0, first, cnt, val);
      total += 3;
      if (first != 6) begin bad++; $display("FAIL single_latency got=%0d exp=6", first); end
      if (cnt != 1) begin bad++; $display("FAIL single_pulses got=%0d exp=1", cnt); end
      if (val !== 16'h1980) begin bad++; $display("FAIL single_sum got=%h exp=1980", val); end
      run1(16'h0100, 16'h0080, 1'b1, first, cnt, val);
      total++;
      if (val !== 16'h1980) begin bad++; $display("FAIL relu_pos got=%h exp=1980", val); end
   endtask

   task automatic test_saturate();
      int first, cnt;
      logic [15:0] val;
      run1(16'h05C0, 16'h0000, 1'b0, first, cnt, val);
      total++;
      if (val !== 16'h7FFF) begin bad++; $display("FAIL sat_pos got=%h exp=7FFF", val); end
      run1(16'hC230, 16'h0000, 1'b0, first, cnt, val);
      total++;
      if (val !== 16'h8000) begin bad++; $display("FAIL sat_neg got=%h exp=8000", val); end
   endtask

   task automatic test_relu();
      int first, cnt;
      logic [15:0] val;
      run1(16'hC230, 16'h0000, 1'b1, first, cnt, val);
      total += 2;
      if (val !== 16'h0000) begin bad++; $display("FAIL relu_neg got=%h exp=0000", val); end
      if (cnt != 1) begin bad++; $display("FAIL relu_pulses got=%0d exp=1", cnt); end
   endtask

   task automatic test_hold_and_clr_drop();
      int cnt;
      // previous result was 0000 from the relu case; use a nonzero one first
      int first;
      logic [15:0] val;
      run1(16'h0100, 16'h0080, 1'b0, first, cnt, val);
      for (int i = 0; i < 4; i++) tick();
      total += 2;
      if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b exp=0", if1.out_valid); end
      if (if1.out_sum !== 16'h1980) begin bad++; $display("FAIL hold_sum got=%h exp=1980", if1.out_sum); end
      clr = 1'b1;
      drive1(1'b1, 16'h0200);
      tick();
      clr = 1'b0;
      drive1(1'b0, 16'h0000);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (if1.out_valid === 1'b1) cnt++;
      end
      total += 2;
      if (cnt != 0) begin bad++; $display("FAIL clr_drop_pulses got=%0d exp=0", cnt); end
      if (if1.out_sum !== 16'h1980) begin bad++; $display("FAIL clr_hold_sum got=%h exp=1980", if1.out_sum); end
   endtask

   task automatic test_group();
      int cnt, c0, c1;
      logic [15:0] v0, v1;
      if3.bias    = 16'hFF00;
      if3.relu_en = 1'b0;
      feed3(16'h0010, 3, 0);
      mon3(15, cnt, c0, c1, v0, v1);
      total += 4;
      if (cnt != 1) begin bad++; $display("FAIL group_pulses got=%0d exp=1", cnt); end
      if (c0 != 6) begin bad++; $display("FAIL group_latency got=%0d exp=6", c0); end
      if (v0 !== 16'h03B0) begin bad++; $display("FAIL group_sum got=%h exp=03B0", v0); end
      if (if3.ch_cnt !== 8'd0) begin bad++; $display("FAIL group_cnt_after got=%0d exp=0", if3.ch_cnt); end
   endtask

   task automatic test_back_to_back();
      int cnt, c0, c1;
      logic [15:0] v0, v1;
      feed3(16'h0010, 3, 0);
      feed3(16'h0020, 3, 0);
      mon3(20, cnt, c0, c1, v0, v1);
      total += 5;
      if (cnt != 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", cnt); end
      if (c0 != 3) begin bad++; $display("FAIL b2b_first_cycle got=%0d exp=3", c0); end
      if (c1 - c0 != 3) begin bad++; $display("FAIL b2b_spacing got=%0d exp=3", c1 - c0); end
      if (v0 !== 16'h03B0) begin bad++; $display("FAIL b2b_sumA got=%h exp=03B0", v0); end
      if (v1 !== 16'h0860) begin bad++; $display("FAIL b2b_sumB got=%h exp=0860", v1); end
   endtask

   task automatic test_midgroup_abort();
      int cnt, c0, c1;
      logic [15:0] v0, v1;
      feed3(16'h0010, 2, 0);
      for (int i = 0; i < 8; i++) tick();
      total++;
      if (if3.ch_cnt !== 8'd2) begin bad++; $display("FAIL partial_cnt got=%0d exp=2", if3.ch_cnt); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      total++;
      if (if3.ch_cnt !== 8'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", if3.ch_cnt); end
      feed3(16'h0010, 3, 0);
      mon3(15, cnt, c0, c1, v0, v1);
      total += 2;
      if (cnt != 1) begin bad++; $display("FAIL clr_group_pulses got=%0d exp=1", cnt); end
      if (v0 !== 16'h03B0) begin bad++; $display("FAIL clr_group_sum got=%h exp=03B0", v0); end

      feed3(16'h0020, 2, 0);
      for (int i = 0; i < 8; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      total += 2;
      if (if3.ch_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", if3.ch_cnt); end
      if (if3.out_sum !== 16'h0000) begin bad++; $display("FAIL rst_sum got=%h exp=0000", if3.out_sum); end
      // gapped vectors: in_valid toggles every cycle
      feed3(16'h0010, 3, 1);
      mon3(15, cnt, c0, c1, v0, v1);
      total += 2;
      if (cnt != 1) begin bad++; $display("FAIL rst_group_pulses got=%0d exp=1", cnt); end
      if (v0 !== 16'h03B0) begin bad++; $display("FAIL rst_group_sum got=%h exp=03B0", v0); end
   endtask

   initial begin
      rst_n = 1'b0;
      clr   = 1'b0;
      drive1(1'b0, 16'h0000);
      drive3(1'b0, 16'h0000);
      if1.bias = 16'h0000; if1.relu_en = 1'b0;
      if3.bias = 16'h0000; if3.relu_en = 1'b0;
      test_reset();
      test_single();
      test_saturate();
      test_relu();
      test_hold_and_clr_drop();
      test_group();
      test_back_to_back();
      test_midgroup_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
